// File: rtl/kernel3_fifo_srl_ctrl.sv
// kernel3_fifo_srl_ctrl
// Occupancy/pointer controller for a shift-register (SRL) FIFO store.
// It turns the producer write handshake and the consumer read handshake into
// a storage shift-enable and a storage read address. It also exports registered
// full/empty flags and the current word count.
// The storage shifts toward higher indices on srl_we, so the oldest word
// always sits at index count-1. The read pointer tracks that index.
module kernel3_fifo_srl_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   num_data_valid,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [CNT_W-1:0]      count_q, count_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  empty_n_q, empty_n_d;
    logic                  full_n_q, full_n_d;
    logic                  push, pop;

    // Accepted transfers, qualified by the clock enables and the registered flags
    always_comb begin
        push = if_write & if_write_ce & full_n_q;
        pop  = if_read & if_read_ce & empty_n_q;
    end

    // Next count and pointer. The pointer holds count-1 and stays at 0 while empty.
    always_comb begin
        count_d = count_q;
        ptr_d   = ptr_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
            if (count_q != '0) begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
            end
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
            if (count_q != CNT_W'(1)) begin
                ptr_d = ptr_q - ADDR_WIDTH'(1);
            end
        end
        empty_n_d = (count_d != '0);
        full_n_d  = (count_d != CNT_W'(DEPTH));
    end

    // State registers; storage contents are left untouched by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            ptr_q     <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            count_q   <= count_d;
            ptr_q     <= ptr_d;
            empty_n_q <= empty_n_d;
            full_n_q  <= full_n_d;
        end
    end

    // Storage controls are pass-through; the flags and count come straight from flops
    always_comb begin
        srl_we         = push;
        srl_din        = if_din;
        srl_addr       = ptr_q;
        if_dout        = srl_dout;
        if_empty_n     = empty_n_q;
        if_full_n      = full_n_q;
        num_data_valid = count_q;
    end

endmodule

// File: tb/tb_kernel3_fifo_srl_ctrl.sv
// Bench for kernel3_fifo_srl_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based FIFO model. Includes a behavioural SRL store.
module tb_kernel3_fifo_srl_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 1;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din, if_dout, srl_din, srl_dout;
    logic          if_full_n, if_empty_n, srl_we;
    logic [CW-1:0] num_data_valid;
    logic [AW-1:0] srl_addr;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ref_q[$];
    logic [DW-1:0] mem[0:(1<<AW)-1];

    always #5 clk = ~clk;

    kernel3_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
        .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
        .num_data_valid(num_data_valid), .srl_we(srl_we), .srl_addr(srl_addr),
        .srl_din(srl_din), .srl_dout(srl_dout)
    );

    // Shift-register storage: new word enters at index 0, older words move up
    always @(posedge clk) begin
        if (srl_we) begin
            for (int i = (1 << AW) - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= srl_din;
        end
    end
    assign srl_dout = mem[srl_addr];

    task automatic set_in(input bit w, input bit wce, input logic [DW-1:0] d, input bit r, input bit rce);
        if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
        #1;
    endtask

    // Advance one clock and apply the FIFO rules to the model
    task automatic tick();
        bit mp, mq;
        logic [DW-1:0] d;
        mp = if_write && if_write_ce && (ref_q.size() < DEPTH);
        mq = if_read && if_read_ce && (ref_q.size() > 0);
        d  = if_din;
        @(posedge clk);
        if (mq) void'(ref_q.pop_front());
        if (mp) ref_q.push_back(d);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        total++; if (if_empty_n !== 1'b0) begin bad++; $display("FAIL reset_empty_n got=%b exp=0", if_empty_n); end
        total++; if (if_full_n !== 1'b1) begin bad++; $display("FAIL reset_full_n got=%b exp=1", if_full_n); end
        total++; if (num_data_valid !== CW'(0)) begin bad++; $display("FAIL reset_count got=%0d exp=0", num_data_valid); end
        #2 reset = 1'b0;
        @(posedge clk); #1;
        total++; if (srl_addr !== AW'(0) || if_empty_n !== 1'b0) begin bad++; $display("FAIL reset_release got addr=%0d empty_n=%b exp 0/0", srl_addr, if_empty_n); end
    endtask

    task automatic test_async_reset_midstream();
        set_in(1, 1, 32'h0000_005A, 0, 0);
        tick();
        total++; if (num_data_valid !== CW'(1)) begin bad++; $display("FAIL pre_reset_count got=%0d exp=1", num_data_valid); end
        set_in(0, 0, '0, 0, 0);
        reset = 1'b1;
        #1;
        total++; if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || num_data_valid !== CW'(0)) begin
            bad++; $display("FAIL async_reset got empty_n=%b full_n=%b cnt=%0d exp 0/1/0", if_empty_n, if_full_n, num_data_valid);
        end
        #2 reset = 1'b0;
        ref_q.delete();
        set_in(0, 0, '0, 1, 1);
        total++; if (srl_we !== 1'b0) begin bad++; $display("FAIL read_after_reset_we got=%b exp=0", srl_we); end
        tick();
        total++; if (num_data_valid !== CW'(0) || if_empty_n !== 1'b0) begin
            bad++; $display("FAIL read_after_reset got cnt=%0d empty_n=%b exp 0/0", num_data_valid, if_empty_n);
        end
    endtask

    task automatic test_fill();
        set_in(1, 1, 32'hA5A5_0001, 0, 1);
        total++; if (srl_we !== 1'b1) begin bad++; $display("FAIL fill_we1 got=%b exp=1", srl_we); end
        tick();
        total++; if (if_empty_n !== 1'b1 || num_data_valid !== CW'(1) || if_dout !== 32'hA5A5_0001) begin
            bad++; $display("FAIL fill_first got empty_n=%b cnt=%0d dout=%h exp 1/1/a5a50001", if_empty_n, num_data_valid, if_dout);
        end
        set_in(1, 1, 32'hA5A5_0002, 0, 1);
        tick();
        total++; if (if_full_n !== 1'b0 || num_data_valid !== CW'(2) || srl_addr !== AW'(1)) begin
            bad++; $display("FAIL fill_full got full_n=%b cnt=%0d addr=%0d exp 0/2/1", if_full_n, num_data_valid, srl_addr);
        end
        set_in(1, 1, 32'hA5A5_0003, 0, 1);
        total++; if (srl_we !== 1'b0) begin bad++; $display("FAIL fill_overflow_we got=%b exp=0", srl_we); end
        tick();
        total++; if (num_data_valid !== CW'(2) || if_dout !== 32'hA5A5_0001) begin
            bad++; $display("FAIL fill_overflow got cnt=%0d dout=%h exp 2/a5a50001", num_data_valid, if_dout);
        end
    endtask

    task automatic test_pop_from_full();
        set_in(0, 1, '0, 1, 1);
        total++; if (if_dout !== 32'hA5A5_0001) begin bad++; $display("FAIL pop_head got=%h exp=a5a50001", if_dout); end
        tick();
        total++; if (if_dout !== 32'hA5A5_0002 || num_data_valid !== CW'(1) || if_full_n !== 1'b1) begin
            bad++; $display("FAIL pop_after got dout=%h cnt=%0d full_n=%b exp a5a50002/1/1", if_dout, num_data_valid, if_full_n);
        end
    endtask

    task automatic test_back_to_back();
        set_in(0, 1, '0, 1, 1);
        tick();
        set_in(1, 1, 32'h11, 0, 1);
        tick();
        set_in(1, 1, 32'h22, 1, 1);
        total++; if (if_dout !== 32'h11 || srl_we !== 1'b1) begin
            bad++; $display("FAIL b2b_before got dout=%h we=%b exp 11/1", if_dout, srl_we);
        end
        tick();
        total++; if (if_dout !== 32'h22 || num_data_valid !== CW'(1) || srl_addr !== AW'(0)) begin
            bad++; $display("FAIL b2b_after got dout=%h cnt=%0d addr=%0d exp 22/1/0", if_dout, num_data_valid, srl_addr);
        end
    endtask

    task automatic test_write_read_empty();
        set_in(0, 1, '0, 1, 1);
        tick();
        total++; if (if_empty_n !== 1'b0) begin bad++; $display("FAIL drain_empty_n got=%b exp=0", if_empty_n); end
        set_in(1, 1, 32'h33, 1, 1);
        total++; if (srl_we !== 1'b1) begin bad++; $display("FAIL empty_wr_we got=%b exp=1", srl_we); end
        tick();
        total++; if (if_empty_n !== 1'b1 || if_dout !== 32'h33 || num_data_valid !== CW'(1)) begin
            bad++; $display("FAIL empty_wr got empty_n=%b dout=%h cnt=%0d exp 1/33/1", if_empty_n, if_dout, num_data_valid);
        end
    endtask

    task automatic test_ce_gated();
        set_in(1, 1, 32'h44, 0, 1);
        tick();
        set_in(1, 0, 32'h55, 1, 0);
        for (int k = 0; k < 5; k++) begin
            total++; if (srl_we !== 1'b0) begin bad++; $display("FAIL ce_gated_we cyc=%0d got=%b exp=0", k, srl_we); end
            tick();
            total++; if (num_data_valid !== CW'(2) || if_full_n !== 1'b0 || if_empty_n !== 1'b1 || if_dout !== 32'h33) begin
                bad++; $display("FAIL ce_gated cyc=%0d got cnt=%0d full_n=%b empty_n=%b dout=%h exp 2/0/1/33",
                                k, num_data_valid, if_full_n, if_empty_n, if_dout);
            end
        end
    endtask

    task automatic test_random();
        bit mp;
        int sz;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
                #1;
                total++; if (if_empty_n !== 1'b0 || if_full_n !== 1'b1 || num_data_valid !== CW'(0)) begin
                    bad++; $display("FAIL rnd_reset n=%0d got empty_n=%b full_n=%b cnt=%0d", n, if_empty_n, if_full_n, num_data_valid);
                end
                reset = 1'b0;
                ref_q.delete();
            end
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0);
            mp = if_write && if_write_ce && (ref_q.size() < DEPTH);
            total++; if (srl_we !== mp) begin bad++; $display("FAIL rnd_we n=%0d got=%b exp=%b", n, srl_we, mp); end
            if (ref_q.size() > 0) begin
                total++; if (if_dout !== ref_q[0]) begin bad++; $display("FAIL rnd_dout n=%0d got=%h exp=%h", n, if_dout, ref_q[0]); end
            end
            tick();
            sz = ref_q.size();
            total++;
            if (num_data_valid !== CW'(sz) || if_empty_n !== (sz != 0) || if_full_n !== (sz != DEPTH) ||
                srl_addr !== AW'((sz == 0) ? 0 : sz - 1)) begin
                bad++; $display("FAIL rnd_state n=%0d got cnt=%0d empty_n=%b full_n=%b addr=%0d exp cnt=%0d",
                                n, num_data_valid, if_empty_n, if_full_n, srl_addr, sz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_async_reset_midstream();
        test_fill();
        test_pop_from_full();
        test_back_to_back();
        test_write_read_empty();
        test_ce_gated();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
